// File: rtl/pixel_sched_pkg.sv
// Shared geometry, encodings and constants for the pixel scheduler.
package pixel_sched_pkg;

  // Cell grid: 8x8 cells, CELL_WIDTH must be a power of two (CELL_SHIFT = log2).
  localparam logic [11:0] CELL_WIDTH      = 12'd32;
  localparam int unsigned CELL_SHIFT      = 5;
  localparam logic [11:0] GRID_SPAN       = 12'd256;  // 8 * CELL_WIDTH
  localparam logic [11:0] CELL_POS_WIDTH  = 12'd192;
  localparam logic [11:0] CELL_POS_HEIGHT = 12'd112;

  // Picture overlay box.
  localparam logic [11:0] PIC_POS_WIDTH   = 12'd224;
  localparam logic [11:0] PIC_POS_HEIGHT  = 12'd176;
  localparam logic [11:0] PIC_WIDTH       = 12'd192;
  localparam logic [11:0] PIC_HEIGHT      = 12'd128;

  // Frames spent in the hold screen before the result picture appears.
  localparam int unsigned HOLD_FRAMES     = 60;

  // game_state input encoding.
  localparam logic [1:0] GS_START = 2'd0;
  localparam logic [1:0] GS_PLAY  = 2'd1;
  localparam logic [1:0] GS_WIN   = 2'd2;
  localparam logic [1:0] GS_FAIL  = 2'd3;

  // Screen FSM states.
  localparam logic [1:0] S_START  = 2'd0;
  localparam logic [1:0] S_PLAY   = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  // Picture word select within pic_data_bus ({fail, victory, start}).
  localparam logic [1:0] PIC_START = 2'd0;
  localparam logic [1:0] PIC_WIN   = 2'd1;
  localparam logic [1:0] PIC_FAIL  = 2'd2;

  // Unshown tile index; cell_state values above it fall back to it.
  localparam logic [3:0] CELL_UNSHOWN = 4'd11;

  typedef enum logic [1:0] {
    REG_BG   = 2'd0,
    REG_GRID = 2'd1,
    REG_PIC  = 2'd2
  } region_t;

endpackage

// File: rtl/pixel_sched_if.sv
// Bus bundle between the scan generator / memories and the pixel scheduler.
//
// Handshake: the pixel stream is valid-only. pix_valid qualifies pix_x/pix_y
// in the cycle it is high; there is no ready, the scheduler accepts a pixel
// every cycle and raises rgb_valid exactly three cycles later. Memory reads
// are fire-and-forget: addresses are registered, data returns one cycle later.
interface pixel_sched_if;
  logic         pix_valid;
  logic [11:0]  pix_x;
  logic [11:0]  pix_y;
  logic         frame_start;
  logic [1:0]   game_state;
  logic [2:0]   cursor_x;
  logic [2:0]   cursor_y;
  logic [11:0]  addr_h;
  logic [11:0]  addr_v;
  logic [2:0]   cell_rd_x;
  logic [2:0]   cell_rd_y;
  logic [3:0]   cell_state;
  logic [47:0]  pic_data_bus;
  logic [191:0] cell_data_bus;
  logic [15:0]  rgb_out;
  logic         rgb_valid;
  logic [1:0]   dbg_state;

  modport slave (
    input  pix_valid, pix_x, pix_y, frame_start, game_state, cursor_x, cursor_y,
    input  cell_state, pic_data_bus, cell_data_bus,
    output addr_h, addr_v, cell_rd_x, cell_rd_y, rgb_out, rgb_valid, dbg_state
  );

  modport master (
    output pix_valid, pix_x, pix_y, frame_start, game_state, cursor_x, cursor_y,
    output cell_state, pic_data_bus, cell_data_bus,
    input  addr_h, addr_v, cell_rd_x, cell_rd_y, rgb_out, rgb_valid, dbg_state
  );
endinterface

// File: rtl/pixel_sched_region_decode.sv
// Combinational region classification, cell index and in-tile offset.
module region_decode
  import pixel_sched_pkg::*;
(
  input  logic [11:0] pix_x,
  input  logic [11:0] pix_y,
  input  logic        overlay_on,
  input  logic        grid_on,
  output region_t     region,
  output logic [2:0]  cell_x,
  output logic [2:0]  cell_y,
  output logic [11:0] tile_x,
  output logic [11:0] tile_y,
  output logic        border
);

  logic        in_pic;
  logic        in_grid;
  logic [11:0] off_x;
  logic [11:0] off_y;

  // Region test in priority order; offsets are only formed inside the grid
  // box so the subtraction can never wrap.
  always_comb begin
    in_pic  = (pix_x >= PIC_POS_WIDTH)  && (pix_x < PIC_POS_WIDTH + PIC_WIDTH) &&
              (pix_y >= PIC_POS_HEIGHT) && (pix_y < PIC_POS_HEIGHT + PIC_HEIGHT);
    in_grid = (pix_x >= CELL_POS_WIDTH)  && (pix_x < CELL_POS_WIDTH + GRID_SPAN) &&
              (pix_y >= CELL_POS_HEIGHT) && (pix_y < CELL_POS_HEIGHT + GRID_SPAN);
    off_x   = in_grid ? (pix_x - CELL_POS_WIDTH)  : 12'd0;
    off_y   = in_grid ? (pix_y - CELL_POS_HEIGHT) : 12'd0;
    cell_x  = 3'(off_x >> CELL_SHIFT);
    cell_y  = 3'(off_y >> CELL_SHIFT);
    tile_x  = off_x & (CELL_WIDTH - 12'd1);
    tile_y  = off_y & (CELL_WIDTH - 12'd1);
    border  = (tile_x < 12'd2) || (tile_x >= CELL_WIDTH - 12'd2) ||
              (tile_y < 12'd2) || (tile_y >= CELL_WIDTH - 12'd2);
    if (overlay_on && in_pic)
      region = REG_PIC;
    else if (grid_on && in_grid)
      region = REG_GRID;
    else
      region = REG_BG;
  end

endmodule

// File: rtl/pixel_sched.sv
// Pixel scheduler: screen FSM plus a fixed 3-stage address/data/colour pipeline.
// Frame-level controls take their next-state value in the frame_start cycle so
// the very first pixel of a frame already sees the new screen.
module pixel_sched
  import pixel_sched_pkg::*;
(
  input  logic          vga_clk,
  input  logic          sys_rst_n,
  pixel_sched_if.slave  bus
);

  logic [1:0] state, state_nx;
  logic [5:0] frame_cnt, frame_cnt_nx;
  logic [4:0] blink_cnt, blink_cnt_nx;
  logic       result_win, result_win_nx;

  region_t     region;
  logic [2:0]  cell_x, cell_y;
  logic [11:0] tile_x, tile_y;
  logic        border;
  logic        overlay_on, grid_on, cursor_hit;
  logic [1:0]  pic_sel;

  logic        s1_valid, s1_hit;
  region_t     s1_region;
  logic [1:0]  s1_pic_sel;
  logic [11:0] addr_h_q, addr_v_q;
  logic [2:0]  cell_rd_x_q, cell_rd_y_q;

  logic        s2_valid, s2_hit;
  region_t     s2_region;
  logic [1:0]  s2_pic_sel;

  logic [3:0]  cell_idx;
  logic [15:0] pix_word;
  logic [15:0] rgb_q;
  logic        rgb_valid_q;

  // Screen FSM, hold counter and blink counter; all move only on frame_start.
  always_comb begin
    state_nx      = state;
    frame_cnt_nx  = frame_cnt;
    blink_cnt_nx  = blink_cnt;
    result_win_nx = result_win;
    if (bus.frame_start) begin
      blink_cnt_nx = blink_cnt + 5'd1;
      if (bus.game_state == GS_START) begin
        state_nx = S_START;
      end else begin
        case (state)
          S_START: if (bus.game_state == GS_PLAY) state_nx = S_PLAY;
          S_PLAY: begin
            if (bus.game_state == GS_WIN || bus.game_state == GS_FAIL) begin
              state_nx      = S_HOLD;
              frame_cnt_nx  = 6'd0;
              result_win_nx = (bus.game_state == GS_WIN);
            end
          end
          S_HOLD: begin
            if (frame_cnt == 6'(HOLD_FRAMES - 1))
              state_nx = S_RESULT;
            else
              frame_cnt_nx = frame_cnt + 6'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Frame-level state registers.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_START;
      frame_cnt  <= 6'd0;
      blink_cnt  <= 5'd0;
      result_win <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_cnt  <= frame_cnt_nx;
      blink_cnt  <= blink_cnt_nx;
      result_win <= result_win_nx;
    end
  end

  // What the current frame shows, derived from the state it is entering.
  always_comb begin
    overlay_on = (state_nx == S_START) || (state_nx == S_RESULT);
    grid_on    = (state_nx != S_START);
    if (state_nx == S_START)
      pic_sel = PIC_START;
    else if (result_win_nx)
      pic_sel = PIC_WIN;
    else
      pic_sel = PIC_FAIL;
    cursor_hit = (state_nx == S_PLAY) && blink_cnt_nx[4] && (region == REG_GRID) &&
                 (cell_x == bus.cursor_x) && (cell_y == bus.cursor_y) && border;
  end

  region_decode u_region_decode (
    .pix_x      (bus.pix_x),
    .pix_y      (bus.pix_y),
    .overlay_on (overlay_on),
    .grid_on    (grid_on),
    .region     (region),
    .cell_x     (cell_x),
    .cell_y     (cell_y),
    .tile_x     (tile_x),
    .tile_y     (tile_y),
    .border     (border)
  );

  // S1: register region, cursor hit and memory addresses; grid cells all read
  // their tile from the first cell's address range.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_valid    <= 1'b0;
      s1_region   <= REG_BG;
      s1_pic_sel  <= 2'd0;
      s1_hit      <= 1'b0;
      addr_h_q    <= 12'd0;
      addr_v_q    <= 12'd0;
      cell_rd_x_q <= 3'd0;
      cell_rd_y_q <= 3'd0;
    end else begin
      s1_valid   <= bus.pix_valid;
      s1_region  <= bus.pix_valid ? region : REG_BG;
      s1_pic_sel <= pic_sel;
      s1_hit     <= bus.pix_valid && cursor_hit;
      if (bus.pix_valid && region == REG_GRID) begin
        addr_h_q    <= CELL_POS_WIDTH + tile_x;
        addr_v_q    <= CELL_POS_HEIGHT + tile_y;
        cell_rd_x_q <= cell_x;
        cell_rd_y_q <= cell_y;
      end else begin
        addr_h_q <= bus.pix_x;
        addr_v_q <= bus.pix_y;
      end
    end
  end

  // S2: sideband travels alongside the memory read that is in flight.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s2_valid   <= 1'b0;
      s2_region  <= REG_BG;
      s2_pic_sel <= 2'd0;
      s2_hit     <= 1'b0;
    end else begin
      s2_valid   <= s1_valid;
      s2_region  <= s1_region;
      s2_pic_sel <= s1_pic_sel;
      s2_hit     <= s1_hit;
    end
  end

  // S3 select: memory words are valid now; invalid pixels are forced to black.
  always_comb begin
    cell_idx = (bus.cell_state > CELL_UNSHOWN) ? CELL_UNSHOWN : bus.cell_state;
    pix_word = 16'h0000;
    if (s2_valid) begin
      case (s2_region)
        REG_PIC:  pix_word = bus.pic_data_bus[{s2_pic_sel, 4'b0000} +: 16];
        REG_GRID: pix_word = s2_hit ? ~bus.cell_data_bus[{cell_idx, 4'b0000} +: 16]
                                    :  bus.cell_data_bus[{cell_idx, 4'b0000} +: 16];
        default:  pix_word = 16'h0000;
      endcase
    end
  end

  // S3: registered colour output.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rgb_q       <= 16'h0000;
      rgb_valid_q <= 1'b0;
    end else begin
      rgb_q       <= pix_word;
      rgb_valid_q <= s2_valid;
    end
  end

  assign bus.addr_h    = addr_h_q;
  assign bus.addr_v    = addr_v_q;
  assign bus.cell_rd_x = cell_rd_x_q;
  assign bus.cell_rd_y = cell_rd_y_q;
  assign bus.rgb_out   = rgb_q;
  assign bus.rgb_valid = rgb_valid_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_pixel_sched.sv
// Bench for pixel_sched: memory models, randomized pixel stream, screen-level
// reference model and an output scoreboard.
module tb_pixel_sched;
  import pixel_sched_pkg::*;

  localparam int GX = int'(CELL_POS_WIDTH);
  localparam int GY = int'(CELL_POS_HEIGHT);
  localparam int CW = int'(CELL_WIDTH);
  localparam int PX = int'(PIC_POS_WIDTH);
  localparam int PY = int'(PIC_POS_HEIGHT);
  localparam int PW = int'(PIC_WIDTH);
  localparam int PH = int'(PIC_HEIGHT);

  localparam int SCR_START = 0, SCR_PLAY = 1, SCR_HOLD = 2, SCR_RESULT = 3;

  // ---------------- clock / reset ----------------
  logic vga_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 vga_clk = ~vga_clk;

  pixel_sched_if bus ();

  pixel_sched dut (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  // ---------------- memory contents ----------------
  logic [3:0] map_mem [8][8];

  function automatic logic [15:0] pic_word(input int sel, input logic [11:0] h, input logic [11:0] v);
    return 16'((int'(h) * 37 + int'(v) * 101 + sel * 7919) ^ (sel << 12));
  endfunction

  function automatic logic [15:0] cell_word(input int idx, input logic [11:0] h, input logic [11:0] v);
    return 16'((int'(h) << 4) ^ (int'(v) * 53) ^ (idx * 4099) ^ 16'h5A00);
  endfunction

  // ROMs and map RAM, one cycle read latency.
  always @(posedge vga_clk) begin
    logic [191:0] cb;
    for (int i = 0; i < 12; i++) cb[i*16 +: 16] = cell_word(i, bus.addr_h, bus.addr_v);
    bus.cell_data_bus <= cb;
    bus.pic_data_bus  <= {pic_word(2, bus.addr_h, bus.addr_v),
                          pic_word(1, bus.addr_h, bus.addr_v),
                          pic_word(0, bus.addr_h, bus.addr_v)};
    bus.cell_state    <= map_mem[bus.cell_rd_y][bus.cell_rd_x];
  end

  // ---------------- reference model ----------------
  int m_scr;
  int m_held;
  int m_frames;
  bit m_win;

  task automatic model_reset();
    m_scr = SCR_START; m_held = 0; m_frames = 0; m_win = 1'b0;
  endtask

  task automatic model_frame(input logic [1:0] gs);
    m_frames++;
    if (gs == 2'd0) m_scr = SCR_START;
    else if (m_scr == SCR_START && gs == 2'd1) m_scr = SCR_PLAY;
    else if (m_scr == SCR_PLAY && gs >= 2'd2) begin
      m_scr = SCR_HOLD; m_held = 1; m_win = (gs == 2'd2);
    end else if (m_scr == SCR_HOLD) begin
      if (m_held == 60) m_scr = SCR_RESULT;
      else m_held++;
    end
  endtask

  function automatic logic [16:0] model_pixel(input logic v, input logic [11:0] x, input logic [11:0] y);
    int ix, iy, cx, cy, ox, oy, st;
    logic [15:0] w;
    bit blink;
    ix = int'(x); iy = int'(y);
    if (!v) return 17'd0;
    blink = (m_frames % 32) >= 16;
    if ((m_scr == SCR_START || m_scr == SCR_RESULT) &&
        ix >= PX && ix < PX + PW && iy >= PY && iy < PY + PH)
      return {1'b1, pic_word((m_scr == SCR_START) ? 0 : (m_win ? 1 : 2), x, y)};
    if (m_scr != SCR_START && ix >= GX && ix < GX + 8*CW && iy >= GY && iy < GY + 8*CW) begin
      cx = (ix - GX) / CW; cy = (iy - GY) / CW;
      ox = (ix - GX) % CW; oy = (iy - GY) % CW;
      st = int'(map_mem[cy][cx]);
      if (st > 11) st = 11;
      w = cell_word(st, 12'(GX + ox), 12'(GY + oy));
      if (m_scr == SCR_PLAY && blink && cx == int'(bus.cursor_x) && cy == int'(bus.cursor_y) &&
          (ox < 2 || ox >= CW - 2 || oy < 2 || oy >= CW - 2))
        w = ~w;
      return {1'b1, w};
    end
    return {1'b1, 16'h0000};
  endfunction

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];
  bit sb_on = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  always @(negedge vga_clk) begin
    logic [16:0] e;
    if (sb_on) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: no expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (bus.rgb_valid !== e[16] || bus.rgb_out !== e[15:0]) begin
          n_fail++;
          $display("FAIL sb_pixel at %0t: got valid=%0b rgb=%h, expected valid=%0b rgb=%h",
                   $time, bus.rgb_valid, bus.rgb_out, e[16], e[15:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1: present one cycle of input, record expectation, advance.
  task automatic drive(input logic v, input logic [11:0] x, input logic [11:0] y, input logic fs);
    bus.pix_valid = v; bus.pix_x = x; bus.pix_y = y; bus.frame_start = fs;
    if (fs) model_frame(bus.game_state);
    exp_q.push_back(model_pixel(v, x, y));
    @(posedge vga_clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 12'd0, 12'd0, 1'b0);
  endtask

  task automatic release_reset();
    sys_rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    repeat (3) exp_q.push_back(17'd0);
    sb_on = 1'b1;
  endtask

  task automatic rand_xy(output logic [11:0] x, output logic [11:0] y);
    int edge_x [4];
    edge_x = '{GX - 1, GX, GX + 8*CW - 1, GX + 8*CW};
    case ($urandom_range(0, 3))
      0: begin x = 12'(GX + $urandom_range(0, 8*CW - 1)); y = 12'(GY + $urandom_range(0, 8*CW - 1)); end
      1: begin x = 12'(PX + $urandom_range(0, PW - 1));   y = 12'(PY + $urandom_range(0, PH - 1)); end
      2: begin x = 12'(edge_x[$urandom_range(0, 3)]);     y = 12'(GY + $urandom_range(0, 8*CW)); end
      default: begin x = 12'($urandom_range(0, 799)); y = 12'($urandom_range(0, 599)); end
    endcase
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge vga_clk);
    #1;
    n_checks += 7;
    if (bus.rgb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rgb_valid got=%b expected=0", bus.rgb_valid); end
    if (bus.rgb_out !== 16'h0) begin n_fail++; $display("FAIL reset_rgb_out got=%h expected=0000", bus.rgb_out); end
    if (bus.addr_h !== 12'h0) begin n_fail++; $display("FAIL reset_addr_h got=%h expected=000", bus.addr_h); end
    if (bus.addr_v !== 12'h0) begin n_fail++; $display("FAIL reset_addr_v got=%h expected=000", bus.addr_v); end
    if (bus.cell_rd_x !== 3'd0) begin n_fail++; $display("FAIL reset_cell_rd_x got=%0d expected=0", bus.cell_rd_x); end
    if (bus.cell_rd_y !== 3'd0) begin n_fail++; $display("FAIL reset_cell_rd_y got=%0d expected=0", bus.cell_rd_y); end
    if (bus.dbg_state !== S_START) begin n_fail++; $display("FAIL reset_state got=%0d expected=%0d", bus.dbg_state, S_START); end
    release_reset();
  endtask

  task automatic test_cell_addr(input logic [3:0] st);
    logic [15:0] exp;
    int idx;
    map_mem[0][1] = st;
    idx = (st > 4'd11) ? 11 : int'(st);
    exp = cell_word(idx, 12'(GX + 5), 12'(GY + 5));
    bus.cursor_x = 3'd5; bus.cursor_y = 3'd5;
    bus.game_state = GS_PLAY;
    drive(1'b0, 12'd0, 12'd0, 1'b1);
    drive(1'b1, 12'(GX + 37), 12'(GY + 5), 1'b0);
    n_checks += 4;
    if (bus.cell_rd_x !== 3'd1) begin n_fail++; $display("FAIL cell_rd_x got=%0d expected=1", bus.cell_rd_x); end
    if (bus.cell_rd_y !== 3'd0) begin n_fail++; $display("FAIL cell_rd_y got=%0d expected=0", bus.cell_rd_y); end
    if (bus.addr_h !== 12'(GX + 5)) begin n_fail++; $display("FAIL addr_h got=%0d expected=%0d", bus.addr_h, GX + 5); end
    if (bus.addr_v !== 12'(GY + 5)) begin n_fail++; $display("FAIL addr_v got=%0d expected=%0d", bus.addr_v, GY + 5); end
    idle(2);
    n_checks += 2;
    if (bus.rgb_valid !== 1'b1) begin n_fail++; $display("FAIL cell_latency got valid=%b expected=1", bus.rgb_valid); end
    if (bus.rgb_out !== exp) begin n_fail++; $display("FAIL cell_word st=%0d got=%h expected=%h", st, bus.rgb_out, exp); end
  endtask

  task automatic test_random_play(input int n);
    logic [11:0] x, y;
    bus.game_state = GS_PLAY;
    for (int i = 0; i < n; i++) begin
      if (i % 8 == 0) begin bus.cursor_x = 3'($urandom_range(0, 7)); bus.cursor_y = 3'($urandom_range(0, 7)); end
      rand_xy(x, y);
      drive(1'($urandom_range(0, 1)), x, y, (i % 40 == 0));
    end
  endtask

  task automatic test_cursor();
    logic [15:0] w;
    int idx;
    bus.cursor_x = 3'd7; bus.cursor_y = 3'd7;
    bus.game_state = GS_PLAY;
    idx = (map_mem[7][7] > 4'd11) ? 11 : int'(map_mem[7][7]);
    w = cell_word(idx, 12'(GX), 12'(GY + 10));
    for (int k = 0; k < 2; k++) begin
      for (int f = 0; f < 40 && (((m_frames % 32) >= 16) != (k == 0)); f++)
        drive(1'b0, 12'd0, 12'd0, 1'b1);
      drive(1'b1, 12'(GX + 7*CW), 12'(GY + 7*CW + 10), 1'b0);
      idle(2);
      n_checks++;
      if (bus.rgb_out !== ((k == 0) ? ~w : w)) begin
        n_fail++;
        $display("FAIL cursor_blink%0d got=%h expected=%h", (k == 0), bus.rgb_out, (k == 0) ? ~w : w);
      end
    end
  endtask

  task automatic test_hold_result();
    logic [11:0] x, y;
    logic [15:0] exp;
    bus.game_state = GS_PLAY;
    drive(1'b0, 12'd0, 12'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin rand_xy(x, y); drive(1'b1, x, y, 1'b0); end
    bus.game_state = GS_WIN;
    for (int i = 0; i < 8; i++) begin rand_xy(x, y); drive(1'b1, x, y, 1'b0); end
    n_checks++;
    if (bus.dbg_state !== S_PLAY) begin n_fail++; $display("FAIL midframe_state got=%0d expected=%0d", bus.dbg_state, S_PLAY); end
    for (int f = 0; f < 62; f++) begin
      drive(1'b0, 12'd0, 12'd0, 1'b1);
      n_checks++;
      if (bus.dbg_state !== ((f < 60) ? S_HOLD : S_RESULT)) begin
        n_fail++;
        $display("FAIL hold_frame%0d got=%0d expected=%0d", f, bus.dbg_state, (f < 60) ? S_HOLD : S_RESULT);
      end
      drive(1'b1, 12'(PX + 20 + f), 12'(PY + 10), 1'b0);
      rand_xy(x, y);
      drive(1'b1, x, y, 1'b0);
    end
    exp = pic_word(1, 12'd300, 12'd200);
    drive(1'b1, 12'd300, 12'd200, 1'b0);
    idle(2);
    n_checks++;
    if (bus.rgb_out !== exp) begin n_fail++; $display("FAIL victory_pic got=%h expected=%h", bus.rgb_out, exp); end
  endtask

  task automatic test_reset_in_result();
    logic [15:0] exp;
    drive(1'b1, 12'd260, 12'd190, 1'b0);
    idle(2);
    n_checks++;
    if (bus.rgb_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid got=%b expected=1", bus.rgb_valid); end
    sb_on = 1'b0;
    bus.pix_valid = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (bus.rgb_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid got=%b expected=0", bus.rgb_valid); end
    if (bus.rgb_out !== 16'h0) begin n_fail++; $display("FAIL async_rst_rgb got=%h expected=0000", bus.rgb_out); end
    if (bus.dbg_state !== S_START) begin n_fail++; $display("FAIL async_rst_state got=%0d expected=%0d", bus.dbg_state, S_START); end
    repeat (2) @(posedge vga_clk);
    #1;
    release_reset();
    bus.game_state = GS_WIN;
    drive(1'b0, 12'd0, 12'd0, 1'b1);
    n_checks++;
    if (bus.dbg_state !== S_START) begin n_fail++; $display("FAIL post_rst_state got=%0d expected=%0d", bus.dbg_state, S_START); end
    exp = pic_word(0, 12'd250, 12'd180);
    drive(1'b1, 12'd250, 12'd180, 1'b0);
    idle(2);
    n_checks += 2;
    if (bus.rgb_valid !== 1'b1) begin n_fail++; $display("FAIL start_pic_valid got=%b expected=1", bus.rgb_valid); end
    if (bus.rgb_out !== exp) begin n_fail++; $display("FAIL start_pic got=%h expected=%h", bus.rgb_out, exp); end
  endtask

  task automatic test_random_valid(input int n);
    logic [11:0] x, y;
    int next_fs;
    next_fs = 0;
    for (int i = 0; i < n; i++) begin
      if (i == next_fs) begin
        case ($urandom_range(0, 9))
          0: bus.game_state = GS_START;
          1: bus.game_state = GS_WIN;
          2: bus.game_state = GS_FAIL;
          default: bus.game_state = GS_PLAY;
        endcase
        bus.cursor_x = 3'($urandom_range(0, 7));
        bus.cursor_y = 3'($urandom_range(0, 7));
      end
      rand_xy(x, y);
      drive(1'($urandom_range(0, 1)), x, y, (i == next_fs));
      if (i == next_fs) next_fs = i + int'($urandom_range(3, 10));
    end
  endtask

  initial begin
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        map_mem[r][c] = 4'($urandom_range(0, 15));
    bus.pix_valid = 1'b0; bus.pix_x = '0; bus.pix_y = '0; bus.frame_start = 1'b0;
    bus.game_state = GS_START; bus.cursor_x = '0; bus.cursor_y = '0;
    bus.cell_state = '0; bus.pic_data_bus = '0; bus.cell_data_bus = '0;
    model_reset();

    test_reset();
    test_cell_addr(4'd6);
    test_cell_addr(4'd13);
    test_random_play(300);
    test_cursor();
    test_hold_result();
    test_reset_in_result();
    test_random_valid(400);
    idle(4);
    sb_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
